window_reg_mapper: RTL and testbench
====================================

WINDOW_REG_MAPPER -- requirements
Module: window_reg_mapper

Interface
REQ-001 SHALL have parameter NWIN, default 4, the number of register windows; the physical windowed file is NWIN*16 = 64 registers, all read through mux_64x1.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port rs_addr, input, 5, architectural source register number.
REQ-005 SHALL have port rd_addr, input, 5, architectural destination register number.
REQ-006 SHALL have port wr_req, input, 1, destination write request this cycle.
REQ-007 SHALL have port op_save, input, 1, SAVE executing this cycle.
REQ-008 SHALL have port op_restore, input, 1, RESTORE executing this cycle.
REQ-009 SHALL have port cwp_we / cwp_in, input, 1 / 2, direct CWP load (WRPSR).
REQ-010 SHALL have port wim_we / wim_in, input, 1 / 4, WIM load (WRWIM).
REQ-011 SHALL have port S, output, 6, registered select driven to mux_64x1.
REQ-012 SHALL have port rs_global, output, 1, registered; 1 when rs_addr < 8, meaning the mux output is not the operand.
REQ-013 SHALL have port wr_en, output, 64, registered one-hot write enable into the windowed file.
REQ-014 SHALL have port wr_global / gidx, output, 1 / 3, registered global-register write enable and index.
REQ-015 SHALL have port cwp / wim, output, 2 / 4, current window pointer and window invalid mask.
REQ-016 SHALL have port trap_ovf / trap_unf / op_err, output, 1 each, single-cycle registered pulses.

Function
REQ-017 SHALL map windowed register r (8..31) to physical index (cwp*16 + r - 8) mod 64, so ins of window w alias outs of window w+1 mod 4.
REQ-018 SHALL register S and rs_global one cycle after rs_addr; S uses the CWP value held before any update in that cycle. When rs_addr < 8, S holds 0.
REQ-019 SAVE: new = cwp-1 mod 4; if wim[new]=1, trap_ovf SHALL pulse next cycle and cwp stays unchanged; otherwise cwp <= new.
REQ-020 RESTORE: new = cwp+1 mod 4; if wim[new]=1, trap_unf SHALL pulse and cwp stays unchanged; otherwise cwp <= new.
REQ-021 The trap check SHALL use the WIM value held before any update in that cycle, including when wim_we is asserted in the same cycle.
REQ-022 op_save and op_restore both asserted: neither SHALL take effect, op_err SHALL pulse, and any write is suppressed.
REQ-023 cwp_we SHALL take priority over SAVE/RESTORE: cwp <= cwp_in, no trap pulse, no op_err.
REQ-024 The write translation with SAVE/RESTORE in the same cycle SHALL use the new CWP when there is no trap; on trap or op_err, wr_en = 0 and wr_global = 0.
REQ-025 rd_addr = 0 SHALL produce no write: wr_en = 0 and wr_global = 0.
REQ-026 rd_addr 1..7 SHALL produce wr_global = 1, gidx = rd_addr[2:0], and wr_en = 0.
REQ-027 wr_en SHALL have at most one bit set, valid for exactly one cycle after wr_req; it SHALL be 0 whenever wr_req = 0.
REQ-028 CWP arithmetic SHALL wrap modulo 4 with no saturation.

Reset
REQ-029 reset_n low SHALL immediately set cwp=0, wim=0, S=0, rs_global=0, wr_en=0, wr_global=0, gidx=0, trap_ovf=0, trap_unf=0, op_err=0, regardless of clk.
REQ-030 Reset asserted mid-SAVE SHALL discard the SAVE; the first operation after release SHALL see cwp=0.

Verification
REQ-031 After reset, cwp=0: rs_addr=8 -> S=0 next cycle; rs_addr=31 -> S=23; rs_addr=3 -> rs_global=1, S=0.
REQ-032 cwp_we with cwp_in=3, then rs_addr=24 -> S=0 (wrap; ins of window 3 = outs of window 0); rs_addr=16 -> S=56.
REQ-033 wim=0001, cwp=1, SAVE -> trap_ovf=1 for one cycle, cwp stays 1. wim=0000, cwp=0, SAVE -> cwp=3, no trap. wim=0001, cwp=3, RESTORE -> trap_unf=1.
REQ-034 cwp=2, SAVE with wr_req, rd_addr=16, no trap -> cwp=1 and wr_en has only bit 24 set. With a trap in the same case -> wr_en=0.
REQ-035 wr_req with rd_addr=0 -> wr_en=0, wr_global=0. rd_addr=5 -> wr_global=1, gidx=5. op_save and op_restore together -> op_err pulse, cwp unchanged.
REQ-036 reset_n pulsed low between clock edges during SAVE -> all outputs 0 immediately; cwp=0 after release.

Source files
------------

// File: rtl/window_reg_mapper.sv
// Windowed register-file address mapper: translates architectural registers to
// physical mux select / one-hot write enables and manages CWP/WIM with traps.
module window_reg_mapper #(
    parameter int NWIN = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [4:0]                 rs_addr,
    input  logic [4:0]                 rd_addr,
    input  logic                       wr_req,
    input  logic                       op_save,
    input  logic                       op_restore,
    input  logic                       cwp_we,
    input  logic [$clog2(NWIN)-1:0]    cwp_in,
    input  logic                       wim_we,
    input  logic [NWIN-1:0]            wim_in,
    output logic [$clog2(NWIN*16)-1:0] S,
    output logic                       rs_global,
    output logic [NWIN*16-1:0]         wr_en,
    output logic                       wr_global,
    output logic [2:0]                 gidx,
    output logic [$clog2(NWIN)-1:0]    cwp,
    output logic [NWIN-1:0]            wim,
    output logic                       trap_ovf,
    output logic                       trap_unf,
    output logic                       op_err
);
    localparam int NPHYS = NWIN * 16;
    localparam int CW    = $clog2(NWIN);
    localparam int PW    = $clog2(NPHYS);

    logic [CW-1:0]    r_cwp;
    logic [NWIN-1:0]  r_wim;
    logic [PW-1:0]    r_s;
    logic             r_rs_global;
    logic [NPHYS-1:0] r_wr_en;
    logic             r_wr_global;
    logic [2:0]       r_gidx;
    logic             r_trap_ovf;
    logic             r_trap_unf;
    logic             r_op_err;

    logic [CW-1:0]    w_cwp_dec;
    logic [CW-1:0]    w_cwp_inc;
    logic [CW-1:0]    w_cwp_next;
    logic             w_trap_ovf;
    logic             w_trap_unf;
    logic             w_op_err;
    logic             w_wr_block;
    logic             w_wr_global;
    logic             w_wr_win;
    logic [PW-1:0]    w_wr_idx;
    logic [NPHYS-1:0] w_wr_onehot;

    // Window w starts at w*16; ins (r24..31) of window w land on outs of w+1.
    function automatic logic [PW-1:0] phys_idx(input logic [CW-1:0] win, input logic [4:0] r);
        logic [PW:0] sum;
        sum = (PW+1)'(win) * (PW+1)'(16) + (PW+1)'(r) - (PW+1)'(8);
        if (sum >= (PW+1)'(NPHYS))
            sum = sum - (PW+1)'(NPHYS);
        return sum[PW-1:0];
    endfunction

    assign w_cwp_dec = (r_cwp == '0) ? CW'(NWIN - 1) : r_cwp - CW'(1);
    assign w_cwp_inc = (r_cwp == CW'(NWIN - 1)) ? '0 : r_cwp + CW'(1);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_cwp_next = r_cwp;
        w_trap_ovf = 1'b0;
        w_trap_unf = 1'b0;
        w_op_err   = 1'b0;
        w_wr_block = 1'b0;
        if (cwp_we) begin
            w_cwp_next = cwp_in;
        end else if (op_save && op_restore) begin
            w_op_err   = 1'b1;
            w_wr_block = 1'b1;
        end else if (op_save) begin
            if (r_wim[w_cwp_dec]) begin
                w_trap_ovf = 1'b1;
                w_wr_block = 1'b1;
            end else begin
                w_cwp_next = w_cwp_dec;
            end
        end else if (op_restore) begin
            if (r_wim[w_cwp_inc]) begin
                w_trap_unf = 1'b1;
                w_wr_block = 1'b1;
            end else begin
                w_cwp_next = w_cwp_inc;
            end
        end
    end

    // Destination translation follows the window this cycle's operation selects.
    assign w_wr_global = wr_req && !w_wr_block && (rd_addr != 5'd0) && (rd_addr < 5'd8);
    assign w_wr_win    = wr_req && !w_wr_block && (rd_addr >= 5'd8);
    assign w_wr_idx    = phys_idx(w_cwp_next, rd_addr);
    assign w_wr_onehot = w_wr_win ? (NPHYS'(1) << w_wr_idx) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cwp       <= '0;
            r_wim       <= '0;
            r_s         <= '0;
            r_rs_global <= 1'b0;
            r_wr_en     <= '0;
            r_wr_global <= 1'b0;
            r_gidx      <= '0;
            r_trap_ovf  <= 1'b0;
            r_trap_unf  <= 1'b0;
            r_op_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values (old CWP/WIM).
            r_cwp       <= w_cwp_next;
            if (wim_we)
                r_wim <= wim_in;
            r_s         <= (rs_addr < 5'd8) ? '0 : phys_idx(r_cwp, rs_addr);
            r_rs_global <= (rs_addr < 5'd8);
            r_wr_en     <= w_wr_onehot;
            r_wr_global <= w_wr_global;
            r_gidx      <= w_wr_global ? rd_addr[2:0] : 3'd0;
            r_trap_ovf  <= w_trap_ovf;
            r_trap_unf  <= w_trap_unf;
            r_op_err    <= w_op_err;
        end
    end

    assign S         = r_s;
    assign rs_global = r_rs_global;
    assign wr_en     = r_wr_en;
    assign wr_global = r_wr_global;
    assign gidx      = r_gidx;
    assign cwp       = r_cwp;
    assign wim       = r_wim;
    assign trap_ovf  = r_trap_ovf;
    assign trap_unf  = r_trap_unf;
    assign op_err    = r_op_err;
endmodule

// File: tb/tb_window_reg_mapper.sv
// Self-checking bench for window_reg_mapper: arithmetic reference model compared
// every cycle, plus hand-computed directed expectations.
module tb_window_reg_mapper;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  rs_addr, rd_addr;
    logic        wr_req, op_save, op_restore, cwp_we, wim_we;
    logic [1:0]  cwp_in;
    logic [3:0]  wim_in;
    logic [5:0]  S;
    logic        rs_global, wr_global, trap_ovf, trap_unf, op_err;
    logic [63:0] wr_en;
    logic [2:0]  gidx;
    logic [1:0]  cwp;
    logic [3:0]  wim;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    window_reg_mapper #(.NWIN(4)) dut (
        .clk(clk), .reset_n(reset_n), .rs_addr(rs_addr), .rd_addr(rd_addr),
        .wr_req(wr_req), .op_save(op_save), .op_restore(op_restore),
        .cwp_we(cwp_we), .cwp_in(cwp_in), .wim_we(wim_we), .wim_in(wim_in),
        .S(S), .rs_global(rs_global), .wr_en(wr_en), .wr_global(wr_global),
        .gidx(gidx), .cwp(cwp), .wim(wim), .trap_ovf(trap_ovf),
        .trap_unf(trap_unf), .op_err(op_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on window numbers.
    int          m_cwp, m_wim;
    int          e_s;
    bit          e_rs_global, e_wr_global, e_ovf, e_unf, e_err;
    int          e_gidx;
    logic [63:0] e_wr_en;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cwp = 0; m_wim = 0; e_s = 0; e_rs_global = 0; e_wr_global = 0;
            e_ovf = 0; e_unf = 0; e_err = 0; e_gidx = 0; e_wr_en = '0;
        end else begin
            int nxt, cand;
            bit blocked;
            nxt = m_cwp; blocked = 0; e_ovf = 0; e_unf = 0; e_err = 0;
            if (cwp_we) nxt = int'(cwp_in);
            else if (op_save && op_restore) begin e_err = 1; blocked = 1; end
            else if (op_save) begin
                cand = (m_cwp + 3) % 4;
                if ((m_wim >> cand) & 1) begin e_ovf = 1; blocked = 1; end
                else nxt = cand;
            end else if (op_restore) begin
                cand = (m_cwp + 1) % 4;
                if ((m_wim >> cand) & 1) begin e_unf = 1; blocked = 1; end
                else nxt = cand;
            end
            e_rs_global = (rs_addr < 8);
            e_s = (rs_addr < 8) ? 0 : (m_cwp * 16 + int'(rs_addr) - 8) % 64;
            e_wr_en = '0; e_wr_global = 0; e_gidx = 0;
            if (wr_req && !blocked) begin
                if (rd_addr >= 8) e_wr_en = 64'd1 << ((nxt * 16 + int'(rd_addr) - 8) % 64);
                else if (rd_addr != 0) begin e_wr_global = 1; e_gidx = int'(rd_addr); end
            end
            if (wim_we) m_wim = int'(wim_in);
            m_cwp = nxt;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && reset_n) begin
            check("m_S", 64'(S), 64'(e_s));
            check("m_rs_global", 64'(rs_global), 64'(e_rs_global));
            check("m_wr_en", wr_en, e_wr_en);
            check("m_wr_global", 64'(wr_global), 64'(e_wr_global));
            check("m_gidx", 64'(gidx), 64'(e_gidx));
            check("m_cwp", 64'(cwp), 64'(m_cwp));
            check("m_wim", 64'(wim), 64'(m_wim));
            check("m_trap_ovf", 64'(trap_ovf), 64'(e_ovf));
            check("m_trap_unf", 64'(trap_unf), 64'(e_unf));
            check("m_op_err", 64'(op_err), 64'(e_err));
        end
    end

    task automatic clr();
        rs_addr = 0; rd_addr = 0; wr_req = 0; op_save = 0; op_restore = 0;
        cwp_we = 0; cwp_in = 0; wim_we = 0; wim_in = 0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input logic [1:0] c, input logic [3:0] w);
        clr(); cwp_we = 1; cwp_in = c; wim_we = 1; wim_in = w;
        tick(); clr();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_S"}, 64'(S), 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_cwp"}, 64'(cwp), 0);
        check({tag, "_wim"}, 64'(wim), 0);
        check({tag, "_flags"}, 64'({rs_global, wr_global, gidx, trap_ovf, trap_unf, op_err}), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        reset_n = 0;
        #23;
        check_all_zero("reset");
        tick(); reset_n = 1; cmp_en = 1;

        rs_addr = 8;  tick(); check("s_r8_cwp0", 64'(S), 0); check("rsg_r8", 64'(rs_global), 0);
        rs_addr = 31; tick(); check("s_r31_cwp0", 64'(S), 23);
        rs_addr = 3;  tick(); check("rsg_r3", 64'(rs_global), 1); check("s_r3", 64'(S), 0);

        clr(); cwp_we = 1; cwp_in = 3; tick(); check("cwp_load3", 64'(cwp), 3);
        clr(); rs_addr = 24; tick(); check("s_r24_cwp3_wrap", 64'(S), 0);
        rs_addr = 16; tick(); check("s_r16_cwp3", 64'(S), 56);

        load(2'd1, 4'b0001);
        op_save = 1; tick(); check("save_ovf", 64'(trap_ovf), 1); check("save_ovf_cwp", 64'(cwp), 1);
        clr(); tick(); check("ovf_one_cycle", 64'(trap_ovf), 0);

        load(2'd0, 4'b0000);
        op_save = 1; tick(); check("save_wrap_cwp", 64'(cwp), 3); check("save_no_trap", 64'(trap_ovf), 0);

        clr(); wim_we = 1; wim_in = 4'b0001; tick();
        clr(); op_restore = 1; tick(); check("restore_unf", 64'(trap_unf), 1); check("restore_unf_cwp", 64'(cwp), 3);

        // Trap check sees the old WIM even while WIM is rewritten.
        clr(); op_restore = 1; wim_we = 1; wim_in = 4'b0000; tick();
        check("old_wim_unf", 64'(trap_unf), 1); check("old_wim_cwp", 64'(cwp), 3); check("wim_written", 64'(wim), 0);

        clr(); op_restore = 1; tick(); check("restore_wrap_cwp", 64'(cwp), 0);

        load(2'd2, 4'b0000);
        op_save = 1; wr_req = 1; rd_addr = 16; tick();
        check("save_wr_cwp", 64'(cwp), 1); check("save_wr_en", wr_en, 64'd1 << 24);

        load(2'd2, 4'b0010);
        op_save = 1; wr_req = 1; rd_addr = 16; tick();
        check("trap_wr_en", wr_en, 0); check("trap_cwp", 64'(cwp), 2); check("trap_pulse", 64'(trap_ovf), 1);

        clr(); wr_req = 1; rd_addr = 0; tick();
        check("rd0_wr_en", wr_en, 0); check("rd0_wr_global", 64'(wr_global), 0);
        rd_addr = 5; tick();
        check("rd5_wr_global", 64'(wr_global), 1); check("rd5_gidx", 64'(gidx), 5); check("rd5_wr_en", wr_en, 0);
        clr(); tick(); check("no_req_wr_en", wr_en, 0);

        clr(); op_save = 1; op_restore = 1; wr_req = 1; rd_addr = 16; tick();
        check("op_err", 64'(op_err), 1); check("op_err_cwp", 64'(cwp), 2); check("op_err_wr_en", wr_en, 0);
        clr(); tick(); check("op_err_one_cycle", 64'(op_err), 0);

        clr(); op_save = 1; cwp_we = 1; cwp_in = 0; tick();
        check("cwp_we_prio", 64'(cwp), 0); check("cwp_we_no_trap", 64'(trap_ovf), 0);

        for (int i = 0; i < 40; i++) begin
            rs_addr    = 5'($urandom_range(0, 31));
            rd_addr    = 5'($urandom_range(0, 31));
            wr_req     = 1'($urandom_range(0, 1));
            op_save    = ($urandom_range(0, 2) == 0);
            op_restore = ($urandom_range(0, 2) == 0);
            cwp_we     = ($urandom_range(0, 7) == 0);
            cwp_in     = 2'($urandom_range(0, 3));
            wim_we     = ($urandom_range(0, 4) == 0);
            wim_in     = 4'($urandom_range(0, 15));
            tick();
        end

        // Reset pulsed between edges while a SAVE is presented.
        load(2'd2, 4'b0000);
        rs_addr = 31; tick();
        op_save = 1; wr_req = 1; rd_addr = 20;
        #2 reset_n = 0;
        #1 check_all_zero("midreset");
        tick(); clr(); reset_n = 1;
        check("post_reset_cwp", 64'(cwp), 0);
        op_save = 1; tick(); check("first_save_after_reset", 64'(cwp), 3);
        clr(); tick();

        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
